spi_ram_ctrl: RTL and testbench
===============================

// Module: spi_ram_ctrl
// PURPOSE
//  Single-port RAM with a command decoder. Sits directly downstream of the SPI slave.
//  - Consumes each 10-bit rx_data word (2-bit command + 8-bit payload) qualified by rx_valid.
//  - Returns read data on tx_data/tx_valid, which the slave shifts out on MISO.
//  - Separate write and read address pointers, optional auto-increment, error flags.
// PARAMETERS
//  MEM_DEPTH      256  number of 8-bit words; legal addresses 0..MEM_DEPTH-1
//  ADDR_SIZE      8    address pointer width; MEM_DEPTH <= 2**ADDR_SIZE
//  ADDR_AUTO_INC  0    1 = pointer increments after each data access, wraps mod 2**ADDR_SIZE
// PORTS
//  clk        in   1   clock; all logic on posedge
//  rst_n      in   1   reset, synchronous, active-low
//  rx_data    in   10  [9:8] command, [7:0] payload, from SPI slave
//  rx_valid   in   1   rx_data valid; level from slave, may stay high many cycles
//  tx_data    out  8   read data to SPI slave
//  tx_valid   out  1   tx_data valid; held high until next accepted command
//  addr_err   out  1   1-cycle pulse: data access to an address >= MEM_DEPTH
//  seq_err    out  1   1-cycle pulse: data command with no loaded address
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge):
//    - tx_data=0, tx_valid=0, addr_err=0, seq_err=0.
//    - wr_addr=0, rd_addr=0, wr_vld=0, rd_vld=0, tx FSM=TX_IDLE.
//    - rx_valid_q=1, so an rx_valid held high across reset is NOT accepted; a fresh 0->1 is required.
//    - Memory contents are not reset.
//  - Accept: acc = rx_valid & ~rx_valid_q; rx_valid_q <= rx_valid every cycle.
//    - Exactly one command is executed per rx_valid rising edge.
//    - All effects are registered at the posedge where acc=1; outputs are visible the following cycle.
//  - Commands (cmd=rx_data[9:8], pl=rx_data[7:0], pl truncated/zero-extended to ADDR_SIZE):
//    - 00 WR_ADDR: wr_addr<=pl; wr_vld<=1.
//    - 01 WR_DATA: if !wr_vld -> seq_err, no write.
//      - elif wr_addr>=MEM_DEPTH -> addr_err, no write.
//      - else mem[wr_addr]<=pl. If ADDR_AUTO_INC, wr_addr<=wr_addr+1 (also on addr_err).
//    - 10 RD_ADDR: rd_addr<=pl; rd_vld<=1.
//    - 11 RD_DATA: pl ignored. if !rd_vld -> seq_err, tx_valid stays 0.
//      - elif rd_addr>=MEM_DEPTH -> addr_err, tx_data<=0, tx_valid<=1.
//      - else tx_data<=mem[rd_addr], tx_valid<=1.
//      - If ADDR_AUTO_INC, rd_addr<=rd_addr+1 on any non-seq_err RD_DATA.
//  - tx FSM:
//    - TX_IDLE -> TX_HOLD on an accepted RD_DATA that sets tx_valid.
//    - TX_HOLD -> TX_IDLE on any accepted command (tx_valid<=0 at that edge), except RD_DATA,
//      which reloads tx_data and stays in TX_HOLD with tx_valid=1 continuously.
//    - tx_data is stable for the whole TX_HOLD period; the slave needs it for 8 shift cycles.
//  - Error flags are high for exactly the one cycle after the offending accept; otherwise 0.
//  - Addresses and the wr_vld/rd_vld flags persist across commands; only reset clears them.
//  - Write then read of the same address: the read returns the new data (write completes first).
//  - Wrap: with ADDR_AUTO_INC=1, pointer 2**ADDR_SIZE-1 increments to 0.
//  - Reset asserted mid-hold drops tx_valid at the reset edge.
//  - Illegal/X command bits are treated as no-op; no state changes.
// TESTING
//  - Reset, then rx_valid held high 20 cycles with 00_0x12 -> exactly one accept; wr_addr=0x12.
//  - 00_0x12, 01_0xA5, 10_0x12, 11_0x00 -> tx_valid=1, tx_data=0xA5, held stable until next accept.
//  - After reset, 11_0x00 first -> seq_err pulse of 1 cycle, tx_valid stays 0.
//    - Same for 01_0x33 with no address loaded -> seq_err, no write.
//  - MEM_DEPTH=200: 00_0xC8 then 01_0x77 -> addr_err pulse, no write.
//    - 10_0xC8 then 11 -> tx_data=0, tx_valid=1.
//  - ADDR_AUTO_INC=1: 00_0xFF, 01_0x11, 01_0x22 -> mem[0xFF]=0x11, mem[0x00]=0x22.
//    - 10_0xFF, 11, 11 -> tx_data 0x11 then 0x22 with tx_valid continuously 1.
//  - rx_valid high at reset release -> no accept until rx_valid falls and rises again.

Source files
------------

// File: rtl/spi_ram_ctrl.sv
// Command-decoding single-port RAM behind an SPI slave. Each rising edge of rx_valid executes
// one 10-bit command. Read data is held on tx_data/tx_valid until the next command is accepted.
module spi_ram_ctrl #(
  parameter int unsigned MEM_DEPTH     = 256,
  parameter int unsigned ADDR_SIZE     = 8,
  parameter int unsigned ADDR_AUTO_INC = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       addr_err,
  output logic       seq_err
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic {TX_IDLE, TX_HOLD} tx_state_t;

  logic [DATA_W-1:0]    mem [MEM_DEPTH];
  logic [ADDR_SIZE-1:0] wr_addr;
  logic [ADDR_SIZE-1:0] rd_addr;
  logic                 wr_vld;
  logic                 rd_vld;
  logic                 rx_valid_q;
  tx_state_t            tx_state;

  logic                 acc;
  logic [1:0]           cmd;
  logic [DATA_W-1:0]    pl;
  logic [ADDR_SIZE-1:0] pl_addr;
  logic                 wr_oob;
  logic                 rd_oob;
  logic                 mem_we;
  logic [DATA_W-1:0]    rd_word;

  // Command decode. An X command fails every case item below and is treated as a no-op.
  always_comb begin
    acc     = rx_valid & ~rx_valid_q;
    cmd     = rx_data[9:8];
    pl      = rx_data[7:0];
    pl_addr = ADDR_SIZE'(pl);
    wr_oob  = 32'(wr_addr) >= MEM_DEPTH;
    rd_oob  = 32'(rd_addr) >= MEM_DEPTH;
    mem_we  = acc && (cmd == CMD_WR_DATA) && wr_vld && !wr_oob;
    rd_word = mem[IDX_W'(rd_addr)];
  end

  // Storage array: no reset, contents survive rst_n.
  always_ff @(posedge clk) begin
    if (mem_we) mem[IDX_W'(wr_addr)] <= pl;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_data    <= '0;
      tx_valid   <= 1'b0;
      addr_err   <= 1'b0;
      seq_err    <= 1'b0;
      wr_addr    <= '0;
      rd_addr    <= '0;
      wr_vld     <= 1'b0;
      rd_vld     <= 1'b0;
      rx_valid_q <= 1'b1;
      tx_state   <= TX_IDLE;
    end else begin
      rx_valid_q <= rx_valid;
      addr_err   <= 1'b0;
      seq_err    <= 1'b0;
      if (acc) begin
        case (cmd)
          CMD_WR_ADDR: begin
            wr_addr  <= pl_addr;
            wr_vld   <= 1'b1;
            tx_valid <= 1'b0;
            tx_state <= TX_IDLE;
          end
          CMD_WR_DATA: begin
            tx_valid <= 1'b0;
            tx_state <= TX_IDLE;
            if (!wr_vld) begin
              seq_err <= 1'b1;
            end else begin
              addr_err <= wr_oob;
              if (ADDR_AUTO_INC != 0) wr_addr <= wr_addr + ADDR_SIZE'(1);
            end
          end
          CMD_RD_ADDR: begin
            rd_addr  <= pl_addr;
            rd_vld   <= 1'b1;
            tx_valid <= 1'b0;
            tx_state <= TX_IDLE;
          end
          CMD_RD_DATA: begin
            if (!rd_vld) begin
              seq_err  <= 1'b1;
              tx_valid <= 1'b0;
              tx_state <= TX_IDLE;
            end else begin
              // Out-of-range reads still complete, returning zero, so the slave never stalls.
              addr_err <= rd_oob;
              tx_data  <= rd_oob ? '0 : rd_word;
              tx_valid <= 1'b1;
              tx_state <= TX_HOLD;
              if (ADDR_AUTO_INC != 0) rd_addr <= rd_addr + ADDR_SIZE'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Directed bench for spi_ram_ctrl. Instance a is 256 deep with auto-increment and instance b is
// 200 deep without it. Both receive the same command stream.
module tb_spi_ram_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] rx_data;
  logic       rx_valid;

  logic [7:0] a_tx_data, b_tx_data;
  logic       a_tx_valid, b_tx_valid;
  logic       a_addr_err, b_addr_err;
  logic       a_seq_err, b_seq_err;

  // values captured one cycle after each accept
  logic [7:0] a_txd, b_txd;
  logic       a_txv, b_txv, a_ae, b_ae, a_se, b_se;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8), .ADDR_AUTO_INC(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(a_tx_data), .tx_valid(a_tx_valid), .addr_err(a_addr_err), .seq_err(a_seq_err)
  );

  spi_ram_ctrl #(.MEM_DEPTH(200), .ADDR_SIZE(8), .ADDR_AUTO_INC(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(b_tx_data), .tx_valid(b_tx_valid), .addr_err(b_addr_err), .seq_err(b_seq_err)
  );

  // Tasks start and end on a negedge.
  task automatic do_reset();
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic send(input logic [1:0] cmd, input logic [7:0] pl);
    rx_data  = {cmd, pl};
    rx_valid = 1'b1;
    @(negedge clk);
    a_txd = a_tx_data;  b_txd = b_tx_data;
    a_txv = a_tx_valid; b_txv = b_tx_valid;
    a_ae  = a_addr_err; b_ae  = b_addr_err;
    a_se  = a_seq_err;  b_se  = b_seq_err;
    rx_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = '0;
    repeat (2) @(negedge clk);
    total++;
    if ({a_tx_data, a_tx_valid, a_addr_err, a_seq_err} !== 11'h0) begin
      bad++;
      $display("FAIL reset_a got data=%h v=%b ae=%b se=%b exp all 0",
               a_tx_data, a_tx_valid, a_addr_err, a_seq_err);
    end
    total++;
    if ({b_tx_data, b_tx_valid, b_addr_err, b_seq_err} !== 11'h0) begin
      bad++;
      $display("FAIL reset_b got data=%h v=%b ae=%b se=%b exp all 0",
               b_tx_data, b_tx_valid, b_addr_err, b_seq_err);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_hold_high();
    int se_cnt;
    do_reset();
    rx_data  = {2'b00, 8'h12};
    rx_valid = 1'b1;
    repeat (20) @(negedge clk);
    rx_valid = 1'b0;
    @(negedge clk);
    send(2'b01, 8'h5A);
    send(2'b10, 8'h12);
    send(2'b11, 8'h00);
    total++;
    if (b_txd !== 8'h5A || b_txv !== 1'b1) begin
      bad++;
      $display("FAIL hold_wr_addr got data=%h v=%b exp 5a 1", b_txd, b_txv);
    end
    // A held-high RD_DATA with no address loaded must raise exactly one seq_err pulse.
    do_reset();
    se_cnt   = 0;
    rx_data  = {2'b11, 8'h00};
    rx_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (b_seq_err === 1'b1) se_cnt++;
    end
    rx_valid = 1'b0;
    @(negedge clk);
    total++;
    if (se_cnt !== 1) begin
      bad++;
      $display("FAIL hold_one_accept got seq_err pulses=%0d exp 1", se_cnt);
    end
  endtask

  task automatic test_read_basic();
    logic unstable;
    send(2'b00, 8'h12);
    send(2'b01, 8'hA5);
    send(2'b10, 8'h12);
    send(2'b11, 8'h00);
    total++;
    if (a_txd !== 8'hA5 || a_txv !== 1'b1) begin
      bad++;
      $display("FAIL rd_basic_a got data=%h v=%b exp a5 1", a_txd, a_txv);
    end
    total++;
    if (b_txd !== 8'hA5 || b_txv !== 1'b1 || b_ae !== 1'b0) begin
      bad++;
      $display("FAIL rd_basic_b got data=%h v=%b ae=%b exp a5 1 0", b_txd, b_txv, b_ae);
    end
    unstable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (b_tx_data !== 8'hA5 || b_tx_valid !== 1'b1) unstable = 1'b1;
    end
    total++;
    if (unstable !== 1'b0) begin
      bad++;
      $display("FAIL rd_hold_stable got unstable=%b exp 0", unstable);
    end
    send(2'b00, 8'h00);
    total++;
    if (b_txv !== 1'b0 || a_txv !== 1'b0) begin
      bad++;
      $display("FAIL rd_release got va=%b vb=%b exp 0 0", a_txv, b_txv);
    end
  endtask

  task automatic test_seq_err();
    send(2'b00, 8'h00);
    send(2'b01, 8'h5C);
    do_reset();
    send(2'b11, 8'h00);
    total++;
    if (b_se !== 1'b1 || b_txv !== 1'b0 || b_ae !== 1'b0) begin
      bad++;
      $display("FAIL seq_rd got se=%b v=%b ae=%b exp 1 0 0", b_se, b_txv, b_ae);
    end
    total++;
    if (b_seq_err !== 1'b0 || b_tx_valid !== 1'b0) begin
      bad++;
      $display("FAIL seq_pulse_len got se=%b v=%b exp 0 0", b_seq_err, b_tx_valid);
    end
    send(2'b01, 8'h33);
    total++;
    if (a_se !== 1'b1 || b_se !== 1'b1) begin
      bad++;
      $display("FAIL seq_wr got sea=%b seb=%b exp 1 1", a_se, b_se);
    end
    send(2'b10, 8'h00);
    send(2'b11, 8'h00);
    total++;
    if (b_txd !== 8'h5C || a_txd !== 8'h5C) begin
      bad++;
      $display("FAIL seq_no_write got a=%h b=%h exp 5c 5c", a_txd, b_txd);
    end
  endtask

  task automatic test_addr_err();
    send(2'b00, 8'hC8);
    send(2'b01, 8'h77);
    total++;
    if (b_ae !== 1'b1 || a_ae !== 1'b0) begin
      bad++;
      $display("FAIL ae_wr got aea=%b aeb=%b exp 0 1", a_ae, b_ae);
    end
    total++;
    if (b_addr_err !== 1'b0) begin
      bad++;
      $display("FAIL ae_pulse_len got ae=%b exp 0", b_addr_err);
    end
    send(2'b10, 8'hC8);
    send(2'b11, 8'h00);
    total++;
    if (b_txd !== 8'h00 || b_txv !== 1'b1 || b_ae !== 1'b1) begin
      bad++;
      $display("FAIL ae_rd_b got data=%h v=%b ae=%b exp 00 1 1", b_txd, b_txv, b_ae);
    end
    total++;
    if (a_txd !== 8'h77 || a_ae !== 1'b0) begin
      bad++;
      $display("FAIL ae_rd_a got data=%h ae=%b exp 77 0", a_txd, a_ae);
    end
    send(2'b00, 8'hC7);
    send(2'b01, 8'h66);
    send(2'b10, 8'hC7);
    send(2'b11, 8'h00);
    total++;
    if (b_txd !== 8'h66 || b_ae !== 1'b0) begin
      bad++;
      $display("FAIL ae_last_legal got data=%h ae=%b exp 66 0", b_txd, b_ae);
    end
  endtask

  task automatic test_auto_inc();
    send(2'b00, 8'hFF);
    send(2'b01, 8'h11);
    total++;
    if (b_ae !== 1'b1 || a_ae !== 1'b0) begin
      bad++;
      $display("FAIL inc_wr_ff got aea=%b aeb=%b exp 0 1", a_ae, b_ae);
    end
    send(2'b01, 8'h22);
    send(2'b10, 8'hFF);
    send(2'b11, 8'h00);
    total++;
    if (a_txd !== 8'h11 || a_txv !== 1'b1) begin
      bad++;
      $display("FAIL inc_rd_ff got data=%h v=%b exp 11 1", a_txd, a_txv);
    end
    total++;
    if (b_txd !== 8'h00 || b_txv !== 1'b1) begin
      bad++;
      $display("FAIL inc_rd_ff_b got data=%h v=%b exp 00 1", b_txd, b_txv);
    end
    total++;
    if (a_tx_valid !== 1'b1) begin
      bad++;
      $display("FAIL inc_valid_gap got v=%b exp 1", a_tx_valid);
    end
    send(2'b11, 8'h00);
    total++;
    if (a_txd !== 8'h22 || a_txv !== 1'b1) begin
      bad++;
      $display("FAIL inc_rd_wrap got data=%h v=%b exp 22 1", a_txd, a_txv);
    end
  endtask

  task automatic test_back_to_back();
    send(2'b00, 8'h40);
    send(2'b01, 8'h9C);
    send(2'b10, 8'h40);
    send(2'b11, 8'h00);
    total++;
    if (a_txd !== 8'h9C || b_txd !== 8'h9C) begin
      bad++;
      $display("FAIL b2b_wr_rd got a=%h b=%h exp 9c 9c", a_txd, b_txd);
    end
    send(2'b01, 8'h3E);
    send(2'b11, 8'h00);
    total++;
    if (b_txd !== 8'h3E || b_txv !== 1'b1) begin
      bad++;
      $display("FAIL b2b_overwrite got data=%h v=%b exp 3e 1", b_txd, b_txv);
    end
  endtask

  task automatic test_reset_mid_hold();
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if (a_tx_valid !== 1'b0 || b_tx_valid !== 1'b0 || b_tx_data !== 8'h00) begin
      bad++;
      $display("FAIL rst_mid_hold got va=%b vb=%b db=%h exp 0 0 00",
               a_tx_valid, b_tx_valid, b_tx_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_release_high();
    int se_cnt;
    rst_n    = 1'b0;
    rx_data  = {2'b11, 8'h00};
    rx_valid = 1'b1;
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    se_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (a_seq_err === 1'b1 || b_seq_err === 1'b1) se_cnt++;
    end
    total++;
    if (se_cnt !== 0) begin
      bad++;
      $display("FAIL rel_high_no_accept got pulses=%0d exp 0", se_cnt);
    end
    rx_valid = 1'b0;
    @(negedge clk);
    rx_valid = 1'b1;
    @(negedge clk);
    total++;
    if (b_seq_err !== 1'b1 || a_seq_err !== 1'b1) begin
      bad++;
      $display("FAIL rel_high_fresh_edge got sea=%b seb=%b exp 1 1", a_seq_err, b_seq_err);
    end
    rx_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = '0;
    @(negedge clk);
    test_reset();
    test_hold_high();
    do_reset();
    test_read_basic();
    test_seq_err();
    do_reset();
    test_addr_err();
    do_reset();
    test_auto_inc();
    do_reset();
    test_back_to_back();
    test_reset_mid_hold();
    test_reset_release_high();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
